// File: rtl/bram_64_arb_pkg.sv
// Shared types and defaults for the two-requester burst arbiter in front of
// port A of the 512 x 64-bit block RAM.
package bram_64_arb_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int LEN_W_DEF  = 4;
  localparam int REQ_N      = 2;
  localparam int DATA_W     = 64;
  localparam int BE_W       = DATA_W / 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Byte-lane merge used wherever a masked write has to be modelled.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_d,
    input logic [DATA_W-1:0] new_d,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_d;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) res[b*8 +: 8] = new_d[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_64_arb_if.sv
// Bundle of both requester channels plus the RAM port A signals; the arbiter
// sits on the slave side, clients and the RAM on the master side.
interface bram_64_arb_if
  import bram_64_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);

  logic              r0_req_in;
  logic              r0_wr_in;
  logic [ADDR_W-1:0] r0_addr_in;
  logic [LEN_W-1:0]  r0_len_in;
  logic              r0_gnt_out;
  logic              r0_beat_out;
  logic [DATA_W-1:0] r0_wr_d_in;
  logic [BE_W-1:0]   r0_we_in;
  logic [DATA_W-1:0] r0_rd_d_out;
  logic              r0_rd_vld_out;
  logic              r0_done_out;

  logic              r1_req_in;
  logic              r1_wr_in;
  logic [ADDR_W-1:0] r1_addr_in;
  logic [LEN_W-1:0]  r1_len_in;
  logic              r1_gnt_out;
  logic              r1_beat_out;
  logic [DATA_W-1:0] r1_wr_d_in;
  logic [BE_W-1:0]   r1_we_in;
  logic [DATA_W-1:0] r1_rd_d_out;
  logic              r1_rd_vld_out;
  logic              r1_done_out;

  logic              bram_en_out;
  logic [BE_W-1:0]   bram_we_out;
  logic [ADDR_W-1:0] bram_addr_out;
  logic [DATA_W-1:0] bram_wr_d_out;
  logic [DATA_W-1:0] bram_rd_d_in;

  modport slave (
    input  r0_req_in, r0_wr_in, r0_addr_in, r0_len_in, r0_wr_d_in, r0_we_in,
    output r0_gnt_out, r0_beat_out, r0_rd_d_out, r0_rd_vld_out, r0_done_out,
    input  r1_req_in, r1_wr_in, r1_addr_in, r1_len_in, r1_wr_d_in, r1_we_in,
    output r1_gnt_out, r1_beat_out, r1_rd_d_out, r1_rd_vld_out, r1_done_out,
    output bram_en_out, bram_we_out, bram_addr_out, bram_wr_d_out,
    input  bram_rd_d_in
  );

  modport master (
    output r0_req_in, r0_wr_in, r0_addr_in, r0_len_in, r0_wr_d_in, r0_we_in,
    input  r0_gnt_out, r0_beat_out, r0_rd_d_out, r0_rd_vld_out, r0_done_out,
    output r1_req_in, r1_wr_in, r1_addr_in, r1_len_in, r1_wr_d_in, r1_we_in,
    input  r1_gnt_out, r1_beat_out, r1_rd_d_out, r1_rd_vld_out, r1_done_out,
    input  bram_en_out, bram_we_out, bram_addr_out, bram_wr_d_out,
    output bram_rd_d_in
  );

endinterface

// File: rtl/bram_64_arb_rr_arb_2.sv
// Two-way round-robin picker. Purely combinational: ptr_i = 0 favours
// requester 0, ptr_i = 1 favours requester 1; the pointer register is external.
module rr_arb_2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o,
  output logic       ptr_o
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    gnt_o = 2'b00;
    ptr_o = ptr_i;

    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase

    // Favour whichever side did not just win; a sole requester still wins.
    if (gnt_o[0])      ptr_o = 1'b1;
    else if (gnt_o[1]) ptr_o = 1'b0;
  end

endmodule

// File: rtl/bram_64_arb.sv
// Round-robin burst arbiter sharing RAM port A between two clients. One beat
// per cycle in BURST; read data returns one cycle later with a valid strobe.
module bram_64_arb
  import bram_64_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic          clk_in,
  input  logic          rst_in,
  bram_64_arb_if.slave  bus
);

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               is_wr_q, is_wr_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [LEN_W-1:0]   cnt_q,   cnt_d;
  logic               ptr_q,   ptr_d;
  logic [REQ_N-1:0]   rd_vld_q, rd_vld_d;

  logic               beat;
  logic               last_beat;
  logic               decide;
  logic [REQ_N-1:0]   arb_req;
  logic [REQ_N-1:0]   gnt;
  logic               ptr_nxt;
  logic               winner;
  logic [BE_W-1:0]    own_we;
  logic [DATA_W-1:0]  own_wd;

  assign beat      = (state_q == ST_BURST);
  assign last_beat = beat && (cnt_q == '0);
  // A decision can happen while idle or on the final beat, which is what
  // lets back-to-back bursts run without a bubble.
  assign decide    = (state_q == ST_IDLE) || last_beat;
  assign arb_req   = (decide && !rst_in) ? {bus.r1_req_in, bus.r0_req_in} : '0;
  assign winner    = gnt[1];

  rr_arb_2 u_rr_arb_2 (
    .req_i (arb_req),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .ptr_o (ptr_nxt)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    rd_vld_d = '0;

    if (beat && !is_wr_q) rd_vld_d[owner_q] = 1'b1;

    if (decide) begin
      if (gnt != '0) begin
        state_d = ST_BURST;
        owner_d = winner;
        is_wr_d = winner ? bus.r1_wr_in   : bus.r0_wr_in;
        addr_d  = winner ? bus.r1_addr_in : bus.r0_addr_in;
        cnt_d   = winner ? bus.r1_len_in  : bus.r0_len_in;
        ptr_d   = ptr_nxt;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      addr_d = addr_q + 1'b1;
      cnt_d  = cnt_q - 1'b1;
    end
  end

  // NOTE: reset is synchronous and sampled only at the clock edge; it also
  // clears the pending read-valid pipeline so an aborted burst leaves no trace.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      ptr_q    <= 1'b0;
      rd_vld_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q  <= state_d;
      owner_q  <= owner_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  assign own_we = owner_q ? bus.r1_we_in   : bus.r0_we_in;
  assign own_wd = owner_q ? bus.r1_wr_d_in : bus.r0_wr_d_in;

  assign bus.bram_en_out   = beat;
  assign bus.bram_addr_out = beat ? addr_q : '0;
  assign bus.bram_we_out   = (beat && is_wr_q) ? own_we : '0;
  assign bus.bram_wr_d_out = beat ? own_wd : '0;

  assign bus.r0_gnt_out    = gnt[0];
  assign bus.r1_gnt_out    = gnt[1];
  assign bus.r0_beat_out   = beat && !owner_q;
  assign bus.r1_beat_out   = beat &&  owner_q;
  // A reset landing on the last beat aborts the burst, so no done escapes.
  assign bus.r0_done_out   = last_beat && !owner_q && !rst_in;
  assign bus.r1_done_out   = last_beat &&  owner_q && !rst_in;
  assign bus.r0_rd_vld_out = rd_vld_q[0];
  assign bus.r1_rd_vld_out = rd_vld_q[1];
  assign bus.r0_rd_d_out   = bus.bram_rd_d_in;
  assign bus.r1_rd_d_out   = bus.bram_rd_d_in;

endmodule

// File: tb/tb_bram_64_arb.sv
// Bench for bram_64_arb: arbitration vector table, directed burst sequences
// and a randomized run against a transaction-level schedule model.
module tb_bram_64_arb;
  import bram_64_arb_pkg::*;

  localparam int AW   = 9;
  localparam int LW   = 4;
  localparam int NCYC = 1500;
  localparam int NS   = NCYC + 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_64_arb_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

  bram_64_arb #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  // RAM port A model with a backdoor preload path.
  logic [63:0] ram [512];
  logic        pl_en = 1'b0;
  logic [8:0]  pl_addr = '0;
  logic [63:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (bus.bram_en_out) begin
      ram[bus.bram_addr_out] <= merge_bytes(ram[bus.bram_addr_out],
                                            bus.bram_wr_d_out, bus.bram_we_out);
      bus.bram_rd_d_in       <= ram[bus.bram_addr_out];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] gnt_v();  return {bus.r1_gnt_out,    bus.r0_gnt_out};    endfunction
  function automatic logic [1:0] beat_v(); return {bus.r1_beat_out,   bus.r0_beat_out};   endfunction
  function automatic logic [1:0] done_v(); return {bus.r1_done_out,   bus.r0_done_out};   endfunction
  function automatic logic [1:0] vld_v();  return {bus.r1_rd_vld_out, bus.r0_rd_vld_out}; endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int n, input logic req, input logic wr,
                         input logic [8:0] addr, input logic [3:0] len);
    if (n == 0) begin
      bus.r0_req_in = req; bus.r0_wr_in = wr; bus.r0_addr_in = addr; bus.r0_len_in = len;
    end else begin
      bus.r1_req_in = req; bus.r1_wr_in = wr; bus.r1_addr_in = addr; bus.r1_len_in = len;
    end
  endtask

  task automatic set_wd(input int n, input logic [63:0] d, input logic [7:0] we);
    if (n == 0) begin bus.r0_wr_d_in = d; bus.r0_we_in = we; end
    else        begin bus.r1_wr_d_in = d; bus.r1_we_in = we; end
  endtask

  task automatic idle_inputs();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    set_wd(0, '0, '0);
    set_wd(1, '0, '0);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic preload(input logic [8:0] a, input logic [63:0] d);
    step();
    pl_en = 1'b1; pl_addr = a; pl_data = d;
  endtask

  task automatic pl_done();
    step();
    pl_en = 1'b0;
  endtask

  // Single-word burst issued from idle; returns the read data for reads.
  task automatic do_burst(input int n, input logic wr, input logic [8:0] addr,
                          input logic [63:0] wd, input logic [7:0] we,
                          output logic [63:0] rd);
    int t;
    logic g;
    step();
    set_req(n, 1'b1, wr, addr, 4'd0);
    set_wd(n, wd, we);
    #1;
    t = 0;
    g = (n == 0) ? bus.r0_gnt_out : bus.r1_gnt_out;
    while (!g && t < 20) begin
      step(); #1; t++;
      g = (n == 0) ? bus.r0_gnt_out : bus.r1_gnt_out;
    end
    check("burst_gnt", g, 1'b1);
    step();
    set_req(n, 1'b0, 1'b0, '0, '0);
    #1;
    check("burst_en", bus.bram_en_out, 1'b1);
    step();
    #1;
    rd = (n == 0) ? bus.r0_rd_d_out : bus.r1_rd_d_out;
    check("burst_vld", (n == 0) ? bus.r0_rd_vld_out : bus.r1_rd_vld_out, !wr);
  endtask

  typedef struct {
    logic [1:0] req;
    logic [8:0] addr;
    logic [1:0] exp_gnt;
  } vec_t;

  typedef struct {
    bit       v;
    bit       own;
    bit       wr;
    bit [8:0] a;
    bit       last;
  } beat_t;

  beat_t       sched   [NS];
  bit          rd_v    [NS];
  bit          rd_own  [NS];
  logic [63:0] rd_exp  [NS];
  logic [63:0] model_mem [512];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [8];
    logic [63:0] rd;

    // Pointer walk from reset: favoured side alternates, sole requester always wins.
    vecs[0] = '{2'b11, 9'h100, 2'b01};
    vecs[1] = '{2'b11, 9'h101, 2'b10};
    vecs[2] = '{2'b01, 9'h102, 2'b01};
    vecs[3] = '{2'b01, 9'h103, 2'b01};
    vecs[4] = '{2'b11, 9'h104, 2'b10};
    vecs[5] = '{2'b10, 9'h105, 2'b10};
    vecs[6] = '{2'b11, 9'h106, 2'b01};
    vecs[7] = '{2'b00, 9'h107, 2'b00};

    idle_inputs();
    do_reset();
    #1;
    check("rst_en",   bus.bram_en_out,   1'b0);
    check("rst_we",   bus.bram_we_out,   8'h00);
    check("rst_addr", bus.bram_addr_out, 9'h000);
    check("rst_wd",   bus.bram_wr_d_out, 64'h0);
    check("rst_outs", {gnt_v(), beat_v(), done_v(), vld_v()}, 8'h00);

    for (int i = 0; i < 8; i++) begin
      step();
      set_req(0, vecs[i].req[0], 1'b0, vecs[i].addr, 4'd0);
      set_req(1, vecs[i].req[1], 1'b0, vecs[i].addr, 4'd0);
      #1;
      check("vec_gnt", gnt_v(), vecs[i].exp_gnt);
      step();
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0);
      #1;
      check("vec_en",   bus.bram_en_out, |vecs[i].exp_gnt);
      check("vec_beat", beat_v(), vecs[i].exp_gnt);
      check("vec_addr", bus.bram_addr_out, (|vecs[i].exp_gnt) ? vecs[i].addr : 9'h000);
      step();
      #1;
      check("vec_vld", vld_v(), vecs[i].exp_gnt);
    end

    // Single read with preloaded data.
    do_reset();
    for (int i = 0; i < 4; i++) preload(9'h010 + 9'(i), 64'hA0 + 64'(i));
    pl_done();
    step();
    set_req(0, 1'b1, 1'b0, 9'h010, 4'd3);
    #1;
    check("rd_gnt", gnt_v(), 2'b01);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) set_req(0, 1'b0, 1'b0, '0, '0);
      #1;
      check("rd_en", bus.bram_en_out, k <= 4);
      if (k <= 4) check("rd_addr", bus.bram_addr_out, 16 + k - 1);
      check("rd_done", done_v(), (k == 4) ? 2'b01 : 2'b00);
      check("rd_vld", vld_v(), (k >= 2 && k <= 5) ? 2'b01 : 2'b00);
      if (k >= 2 && k <= 5) check("rd_data", bus.r0_rd_d_out, 64'hA0 + 64'(k - 2));
    end

    // Byte-masked write by r1.
    do_burst(1, 1'b1, 9'h020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd);
    do_burst(1, 1'b1, 9'h020, 64'h0, 8'h0F, rd);
    do_burst(1, 1'b0, 9'h020, 64'h0, 8'h00, rd);
    check("bytemask", rd, 64'hFFFF_FFFF_0000_0000);

    // Contention from reset: r0 first, r1 on r0's last beat, en high 4 cycles.
    do_reset();
    step();
    set_req(0, 1'b1, 1'b0, 9'h030, 4'd1);
    set_req(1, 1'b1, 1'b0, 9'h040, 4'd1);
    #1;
    check("ct_gnt", gnt_v(), 2'b01);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) set_req(0, 1'b0, 1'b0, '0, '0);
      if (k == 3) set_req(1, 1'b0, 1'b0, '0, '0);
      #1;
      check("ct_en", bus.bram_en_out, k <= 4);
      check("ct_gnt_k", gnt_v(), (k == 2) ? 2'b10 : 2'b00);
      check("ct_beat", beat_v(), (k <= 2) ? 2'b01 : (k <= 4) ? 2'b10 : 2'b00);
      if (k <= 4) check("ct_addr", bus.bram_addr_out,
                        (k == 1) ? 9'h030 : (k == 2) ? 9'h031 : (k == 3) ? 9'h040 : 9'h041);
    end
    // r0 wins alone, so the next simultaneous request favours r1.
    do_burst(0, 1'b0, 9'h030, 64'h0, 8'h00, rd);
    step();
    set_req(0, 1'b1, 1'b0, 9'h050, 4'd0);
    set_req(1, 1'b1, 1'b0, 9'h060, 4'd0);
    #1;
    check("ct2_gnt_r1", gnt_v(), 2'b10);
    step();
    set_req(1, 1'b0, 1'b0, '0, '0);
    #1;
    check("ct2_gnt_r0", gnt_v(), 2'b01);
    step();
    set_req(0, 1'b0, 1'b0, '0, '0);
    step();
    step();

    // Address wrap.
    step();
    set_req(0, 1'b1, 1'b0, 9'h1FE, 4'd3);
    #1;
    check("wr_gnt", gnt_v(), 2'b01);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) set_req(0, 1'b0, 1'b0, '0, '0);
      #1;
      check("wrap_addr", bus.bram_addr_out, (510 + k - 1) % 512);
    end
    step();
    step();

    // Reset during beat 2 of an r1 read burst.
    step();
    set_req(1, 1'b1, 1'b0, 9'h070, 4'd7);
    #1;
    check("mr_gnt", gnt_v(), 2'b10);
    step();
    set_req(1, 1'b0, 1'b0, '0, '0);
    step();
    step();
    rst = 1'b1;
    #1;
    check("mr_beat2", bus.r1_beat_out, 1'b1);
    check("mr_done_in_rst", done_v(), 2'b00);
    for (int k = 0; k < 4; k++) begin
      step();
      rst = 1'b0;
      #1;
      check("mr_en_after", bus.bram_en_out, 1'b0);
      check("mr_vld_after", vld_v(), 2'b00);
      check("mr_done_after", done_v(), 2'b00);
    end
    // Leave the pointer favouring r1, then reset with both requesting.
    do_burst(0, 1'b0, 9'h000, 64'h0, 8'h00, rd);
    step();
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 9'h080, 4'd0);
    set_req(1, 1'b1, 1'b0, 9'h090, 4'd0);
    #1;
    check("mr_gnt_in_rst", gnt_v(), 2'b00);
    step();
    rst = 1'b0;
    #1;
    check("mr_gnt_after_rst", gnt_v(), 2'b01);
    idle_inputs();
    step();
    step();
    step();

    // Lone requester: five back-to-back single writes without bubbles.
    step();
    set_req(0, 1'b1, 1'b1, 9'h060, 4'd0);
    set_wd(0, 64'h1234_5678_9ABC_DEF0, 8'hFF);
    #1;
    check("lone_gnt0", gnt_v(), 2'b01);
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i < 5) set_req(0, 1'b1, 1'b1, 9'h060 + 9'(i), 4'd0);
      else       set_req(0, 1'b0, 1'b0, '0, '0);
      #1;
      check("lone_en",   bus.bram_en_out, 1'b1);
      check("lone_addr", bus.bram_addr_out, 96 + i - 1);
      check("lone_we",   bus.bram_we_out, 8'hFF);
      check("lone_done", bus.r0_done_out, 1'b1);
      if (i < 5) check("lone_gnt", gnt_v(), 2'b01);
    end
    step();
    #1;
    check("lone_end_en", bus.bram_en_out, 1'b0);
    idle_inputs();

    // Randomized run against a schedule model.
    begin
      bit          c_req  [2];
      bit          c_wr   [2];
      logic [8:0]  c_addr [2];
      logic [3:0]  c_len  [2];
      logic [63:0] wd     [2];
      logic [7:0]  we     [2];
      int          m_last;
      bit          m_ptr;
      int          w;
      logic [1:0]  eg;
      beat_t       bs;

      do_reset();
      for (int a = 0; a < 512; a++) begin
        model_mem[a] = {$urandom, $urandom};
        preload(9'(a), model_mem[a]);
      end
      pl_done();
      m_last = -1;
      m_ptr  = 1'b0;
      for (int n = 0; n < 2; n++) c_req[n] = 1'b0;

      for (int c = 0; c < NCYC; c++) begin
        step();
        for (int n = 0; n < 2; n++) begin
          if (!c_req[n] && $urandom_range(0, 2) == 0) begin
            c_req[n]  = 1'b1;
            c_wr[n]   = 1'($urandom);
            c_addr[n] = 9'($urandom);
            c_len[n]  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
          end
          wd[n] = {$urandom, $urandom};
          we[n] = 8'($urandom);
          set_req(n, c_req[n], c_wr[n], c_addr[n], c_len[n]);
          set_wd(n, wd[n], we[n]);
        end
        #1;

        eg = 2'b00;
        if (c >= m_last && (c_req[0] || c_req[1])) begin
          if (c_req[0] && c_req[1]) w = m_ptr;
          else                      w = c_req[1] ? 1 : 0;
          eg[w] = 1'b1;
          m_ptr = (w == 0);
          for (int k = 0; k <= int'(c_len[w]); k++) begin
            sched[c + 1 + k].v    = 1'b1;
            sched[c + 1 + k].own  = 1'(w);
            sched[c + 1 + k].wr   = c_wr[w];
            sched[c + 1 + k].a    = 9'((int'(c_addr[w]) + k) % 512);
            sched[c + 1 + k].last = (k == int'(c_len[w]));
          end
          m_last = c + 1 + int'(c_len[w]);
        end

        bs = sched[c];
        check("rnd_gnt",  gnt_v(), eg);
        check("rnd_en",   bus.bram_en_out, bs.v);
        check("rnd_addr", bus.bram_addr_out, bs.v ? bs.a : 9'h000);
        check("rnd_beat", beat_v(), bs.v ? (bs.own ? 2'b10 : 2'b01) : 2'b00);
        check("rnd_we",   bus.bram_we_out, (bs.v && bs.wr) ? we[bs.own] : 8'h00);
        check("rnd_wd",   bus.bram_wr_d_out, bs.v ? wd[bs.own] : 64'h0);
        check("rnd_done", done_v(), (bs.v && bs.last) ? (bs.own ? 2'b10 : 2'b01) : 2'b00);
        check("rnd_vld",  vld_v(), rd_v[c] ? (rd_own[c] ? 2'b10 : 2'b01) : 2'b00);
        if (rd_v[c]) check("rnd_rdata", rd_own[c] ? bus.r1_rd_d_out : bus.r0_rd_d_out, rd_exp[c]);

        if (bs.v && bs.wr) begin
          model_mem[bs.a] = merge_bytes(model_mem[bs.a], wd[bs.own], we[bs.own]);
        end else if (bs.v) begin
          rd_v[c + 1]   = 1'b1;
          rd_own[c + 1] = bs.own;
          rd_exp[c + 1] = model_mem[bs.a];
        end

        for (int n = 0; n < 2; n++) if (eg[n]) c_req[n] = 1'b0;
      end
      idle_inputs();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bram_64_arb.md
# bram_64_arb

Two-requester burst arbiter that shares port A of the 512 x 64-bit dual-port block RAM (`bram_64_64`) between two clients, for example a network receive writer and a framebuffer fetcher. It accepts read or write burst requests from each client and arbitrates round-robin between them. It sequences the RAM address, enable and byte-write strobes one beat per cycle and returns read data with a valid strobe. Port B of the RAM is outside the scope of this block.

## Interface
- `ADDR_W`, default 9: RAM word address width.
- `LEN_W`, default 4: burst length field width. A burst is `len+1` words, 1..16.
- `clk_in` input 1: the single clock. The RAM port A clock is tied to it.
- `rst_in` input 1: reset, synchronous, active-high.
- `rN_req_in` input 1: request valid, where N is 0 or 1.
- `rN_wr_in` input 1: 1 = write burst, 0 = read burst.
- `rN_addr_in` input ADDR_W: burst start word address.
- `rN_len_in` input LEN_W: number of words minus 1.
- `rN_gnt_out` output 1: request accepted this cycle. Acceptance is `req && gnt`.
- `rN_beat_out` output 1: a RAM access for requester N issues this cycle.
- `rN_wr_d_in` input 64: write data, sampled when `beat_out` is high.
- `rN_we_in` input 8: byte enables, sampled when `beat_out` is high.
- `rN_rd_d_out` output 64: read data, equal to `bram_rd_d_in` (broadcast).
- `rN_rd_vld_out` output 1: `rd_d` is valid for requester N.
- `rN_done_out` output 1: last beat of requester N's burst.
- `bram_en_out` output 1: RAM port A enable.
- `bram_we_out` output 8: RAM port A byte write enables.
- `bram_addr_out` output ADDR_W: RAM port A address.
- `bram_wr_d_out` output 64: RAM port A write data.
- `bram_rd_d_in` input 64: RAM port A read data, one-cycle latency.

## Operation
- Two states:
  - IDLE: no burst in progress.
  - BURST: registers hold owner, wr, current address and remaining count.
- Decision cycle: IDLE, or the last beat of a burst in BURST.
  - In a decision cycle the arbiter picks a winner among the asserted `req` inputs.
  - `gnt` is combinational and goes only to the winner.
  - At the clock edge the arbiter latches the winner's wr, addr and len and enters BURST.
  - If no request is pending, it goes to IDLE.
- Round-robin: a one-bit pointer favours the requester not granted last. A sole requester is always granted, even if it won last time.
- Requester rules:
  - Hold `req`, `wr`, `addr` and `len` stable until `gnt`.
  - `req` seen in the cycle after `gnt` is a new request.
- BURST, each cycle:
  - `bram_en_out` = 1 and `bram_addr_out` = current address.
  - `beat_out` is high for the owner.
  - `bram_we_out` = `we_in` of the owner if wr, otherwise 0.
  - `bram_wr_d_out` = owner `wr_d_in`, as a combinational mux.
  - Address increments modulo 2^ADDR_W, so 0x1FF wraps to 0x000.
  - Count decrements. The beat with count 0 is last and asserts owner `done_out`.
- Read beats: `rd_vld_out` for the owner is the one-cycle delayed copy of (beat && !wr). Write beats never raise `rd_vld`.
- Whenever no beat is issued, `bram_en_out` = 0, `bram_we_out` = 0 and `bram_wr_d_out` = 0.
- Reset, including mid-burst:
  - The next cycle is IDLE and all outputs are 0.
  - Any pending `rd_vld` is dropped and no `done` is issued.
  - The pointer favours r0.
  - While `rst_in` is high, both `gnt_out` are forced to 0.

## Timing
- Request accepted at cycle T. Beat k (k = 0..len) issues at T+1+k.
- Read data for beat k is valid at T+2+k.
- `done_out` is asserted at T+1+len.
- The next grant can occur at T+1+len, with its first beat at T+2+len. Back-to-back bursts have no idle cycle.
- Minimum latency from idle: `req` at T gives `gnt` at T and the first RAM access at T+1.
- Reset value of every output is 0. `rd_d_out` mirrors `bram_rd_d_in` and is undefined unless `rd_vld_out` is high.

## Structure
- Shared package / include holds:
  - the state encoding (IDLE, BURST);
  - the `ADDR_W` and `LEN_W` defaults;
  - a `REQ_N` = 2 constant.
- Sub-module `rr_arb_2`: a two-way round-robin picker.
  - Inputs: `req[1:0]`, pointer.
  - Outputs: one-hot grant and the next pointer.
  - It is purely combinational; the pointer register lives in `bram_64_arb`.
- The top-level integrator instantiates `bram_64_64` alongside this block, not inside it.

## Test plan
- Single read: preload 0x010..0x013 with 0xA0..0xA3, then r0 reads addr 0x010 with len 3.
  - `gnt` at T and `bram_addr` 0x010..0x013 at T+1..T+4.
  - `r0_rd_vld` at T+2..T+5 with data A0..A3.
  - `r0_done` at T+4 only.
- Byte-masked write: r1 writes 0xFFFF_FFFF_FFFF_FFFF to 0x020 with `we`=0xFF, then 0x0 with `we`=0x0F, then reads 0x020.
  - Read returns 0xFFFF_FFFF_0000_0000.
- Contention from reset: r0 and r1 both request len 1 in the same cycle.
  - r0 is granted first; r1 is granted on r0's last beat.
  - `bram_en` stays high for 4 consecutive cycles.
  - A repeated simultaneous request grants r1 first.
- Wrap: r0 reads addr 0x1FE with len 3.
  - `bram_addr` is 0x1FE, 0x1FF, 0x000, 0x001.
- Reset mid-burst: r1 reads len 7 and `rst_in` is asserted during beat 2.
  - The next cycle has `bram_en` = 0, with no further `rd_vld` and no `done`.
  - After release, a simultaneous request grants r0.
- No starvation of a lone requester: r0 alone issues five back-to-back len 0 writes.
  - r0 is granted every time and `bram_en` stays continuously high with no bubbles.
